// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU datapath widths, weight row type and weight_fetch states
package tpu_pkg;

  localparam int TPU_DATA_WIDTH  = 8;
  localparam int TPU_FIFO_INPUTS = 16;

  typedef logic [TPU_FIFO_INPUTS*TPU_DATA_WIDTH-1:0] row_t;

  typedef enum logic [2:0] {
    WF_IDLE,
    WF_FETCH,
    WF_DRAIN,
`ifdef WEIGHT_FETCH_ZPAD_EN
    WF_PAD,
`endif
    WF_DONE
  } wf_state_t;

endpackage

// File: rtl/weight_fetch_rdpipe.sv
// rtl/weight_fetch_rdpipe.sv - valid shift register tracking outstanding weight-memory reads
module weight_fetch_rdpipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_issue,
  output logic o_valid,
  output logic o_busy
);

  logic [DEPTH-1:0] r_v;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_v <= '0;
    end else begin
      r_v[0] <= i_issue;
      for (int i = 1; i < DEPTH; i++) r_v[i] <= r_v[i-1];
    end
  end

  assign o_valid = r_v[DEPTH-1];
  assign o_busy  = |r_v;

endmodule

// File: rtl/weight_fetch.sv
// rtl/weight_fetch.sv - tile loader from weight memory into weightFIFO
// Optional zero padding of the tile to FIFO_DEPTH rows: WEIGHT_FETCH_ZPAD_EN
module weight_fetch
  import tpu_pkg::*;
#(
  parameter int FIFO_INPUTS = TPU_FIFO_INPUTS,
  parameter int DATA_WIDTH  = TPU_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [$clog2(FIFO_DEPTH):0]       num_rows,
  input  logic [FIFO_INPUTS-1:0]            col_mask,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_rd_en,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [FIFO_INPUTS*DATA_WIDTH-1:0] mem_rd_data,
  output logic [FIFO_INPUTS-1:0]            fifo_en,
  output logic [FIFO_INPUTS*DATA_WIDTH-1:0] weight_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  wf_state_t                       r_state;
  wf_state_t                       w_state_next;
  logic [ADDR_WIDTH-1:0]           r_addr;
  logic [CW-1:0]                   r_remain;
  logic [FIFO_INPUTS-1:0]          r_mask;
  logic [FIFO_INPUTS-1:0]          r_fifo_en;
  logic [FIFO_INPUTS*DATA_WIDTH-1:0] r_weight;
  logic [CW-1:0]                   w_n;
  logic                            w_ret;
  logic                            w_pipe_busy;
`ifdef WEIGHT_FETCH_ZPAD_EN
  logic [CW-1:0]                   r_pushed;
`endif

  assign w_n = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;

  weight_fetch_rdpipe #(.DEPTH(MEM_LATENCY)) u_rdpipe (
    .clk     (clk),
    .i_clr   (reset),
    .i_issue (mem_rd_en),
    .o_valid (w_ret),
    .o_busy  (w_pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= WF_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WF_IDLE: begin
        if (start) begin
          if (w_n != '0) w_state_next = WF_FETCH;
`ifdef WEIGHT_FETCH_ZPAD_EN
          else           w_state_next = WF_DRAIN;
`else
          else           w_state_next = WF_DONE;
`endif
        end
      end
      WF_FETCH: if (r_remain == CW'(1)) w_state_next = WF_DRAIN;
`ifdef WEIGHT_FETCH_ZPAD_EN
      // r_pushed counts rows already presented on weight_out, including this cycle's
      WF_DRAIN: if (!w_pipe_busy) w_state_next = (r_pushed == DEPTH_C) ? WF_DONE : WF_PAD;
      WF_PAD:   if (r_pushed == DEPTH_C) w_state_next = WF_DONE;
`else
      WF_DRAIN: if (!w_pipe_busy) w_state_next = WF_DONE;
`endif
      WF_DONE:  w_state_next = WF_IDLE;
      default:  w_state_next = WF_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != WF_IDLE);
    done       = (r_state == WF_DONE);
    mem_rd_en  = (r_state == WF_FETCH);
    mem_addr   = r_addr;
    fifo_en    = r_fifo_en;
    weight_out = r_weight;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_remain  <= '0;
      r_mask    <= '0;
      r_fifo_en <= '0;
      r_weight  <= '0;
`ifdef WEIGHT_FETCH_ZPAD_EN
      r_pushed  <= '0;
`endif
    end else begin
      if (r_state == WF_IDLE && start) begin
        r_addr   <= base_addr;
        r_remain <= w_n;
        r_mask   <= col_mask;
`ifdef WEIGHT_FETCH_ZPAD_EN
        r_pushed <= '0;
`endif
      end else if (r_state == WF_FETCH) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_remain <= r_remain - CW'(1);
      end
      r_fifo_en <= '0;
      if (w_ret) begin
        r_weight  <= mem_rd_data;
        r_fifo_en <= r_mask;
`ifdef WEIGHT_FETCH_ZPAD_EN
        r_pushed  <= r_pushed + CW'(1);
      end else if (w_state_next == WF_PAD) begin
        r_weight  <= '0;
        r_fifo_en <= r_mask;
        r_pushed  <= r_pushed + CW'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_weight_fetch.sv
// tb/tb_weight_fetch.sv - directed self-checking bench for weight_fetch at latencies 1..3
module tb_weight_fetch;
  import tpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start;
  logic [15:0] base_addr;
  logic [4:0]  num_rows;
  logic [15:0] col_mask;
  wire  [2:0]  busy;
  wire  [2:0]  done;
  wire  [2:0]  rd_en;
  wire  [15:0] addr [3];
  wire  [15:0] fen [3];
  wire  row_t  wout [3];
  wire  row_t  rdata [3];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // Instance g has MEM_LATENCY g+1; memory word is the low address byte in every lane
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [15:0] r_apipe [g+1];
    always @(posedge clk) begin
      r_apipe[0] <= addr[g];
      for (int i = 1; i < g + 1; i++) r_apipe[i] <= r_apipe[i-1];
    end
    assign rdata[g] = {16{r_apipe[g][7:0]}};

    weight_fetch #(.MEM_LATENCY(g + 1)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start[g]),
      .base_addr   (base_addr),
      .num_rows    (num_rows),
      .col_mask    (col_mask),
      .busy        (busy[g]),
      .done        (done[g]),
      .mem_rd_en   (rd_en[g]),
      .mem_addr    (addr[g]),
      .mem_rd_data (rdata[g]),
      .fifo_en     (fen[g]),
      .weight_out  (wout[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // restart_c > 0: extra start at that cycle; -1: extra start on the done cycle.
  // rst_c > 0: reset pulsed in that cycle, everything idle afterwards.
  task automatic run_tile(input int g, input int base, input int num, input logic [15:0] mask,
                          input int restart_c, input int rst_c);
    int L, n, done_c, last_c, k, rs_c;
    logic [15:0] a;
    logic exp_rd, exp_push, exp_busy, exp_done;
    logic [15:0] exp_addr, exp_fen;
    logic [127:0] exp_w;
    L = g + 1;
    n = (num > 16) ? 16 : num;
`ifdef WEIGHT_FETCH_ZPAD_EN
    done_c = (n == 0) ? 18 : 16 + L + 2;
`else
    done_c = (n == 0) ? 1 : n + L + 2;
`endif
    rs_c   = (restart_c < 0) ? done_c : restart_c;
    last_c = (rst_c > 0) ? rst_c + 8 : done_c + 1;
    @(negedge clk);
    base_addr = base[15:0];
    num_rows  = num[4:0];
    col_mask  = mask;
    start[g]  = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      start = '0;
      reset = 1'b0;
      if (c == rs_c) begin
        start[g]  = 1'b1;
        base_addr = base_addr ^ 16'h0100;
      end
      if (c == rst_c) reset = 1'b1;
      exp_rd   = (c <= n);
      exp_addr = 16'(base + c - 1);
      exp_busy = (c <= done_c);
      exp_done = (c == done_c);
`ifdef WEIGHT_FETCH_ZPAD_EN
      k = (n == 0) ? c - 2 : c - L - 2;
      exp_push = (k >= 0 && k < 16);
`else
      k = c - L - 2;
      exp_push = (k >= 0 && k < n);
`endif
      a = 16'(base + k);
      exp_w   = (k < n) ? {16{a[7:0]}} : '0;
      exp_fen = exp_push ? mask : 16'h0000;
      if (rst_c > 0 && c > rst_c) begin
        exp_rd = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_fen = '0;
        check($sformatf("g%0d c%0d addr after reset", g, c), addr[g], 0);
        check($sformatf("g%0d c%0d weight after reset", g, c), wout[g], 0);
      end
      check($sformatf("g%0d c%0d mem_rd_en", g, c), rd_en[g], exp_rd);
      check($sformatf("g%0d c%0d busy", g, c), busy[g], exp_busy);
      check($sformatf("g%0d c%0d done", g, c), done[g], exp_done);
      check($sformatf("g%0d c%0d fifo_en", g, c), fen[g], exp_fen);
      if (exp_rd) check($sformatf("g%0d c%0d mem_addr", g, c), addr[g], exp_addr);
      if (exp_push && !(rst_c > 0 && c > rst_c))
        check($sformatf("g%0d c%0d weight_out", g, c), wout[g], exp_w);
    end
    start = '0;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = '0;
    base_addr = '0;
    num_rows  = '0;
    col_mask  = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("g%0d reset busy", g), busy[g], 0);
      check($sformatf("g%0d reset done", g), done[g], 0);
      check($sformatf("g%0d reset mem_rd_en", g), rd_en[g], 0);
      check($sformatf("g%0d reset mem_addr", g), addr[g], 0);
      check($sformatf("g%0d reset fifo_en", g), fen[g], 0);
      check($sformatf("g%0d reset weight_out", g), wout[g], 0);
    end
    reset = 1'b0;

    run_tile(0, 'h0010, 4,  16'hFFFF, 0, 0);
    run_tile(2, 'h0200, 20, 16'hA5A5, 0, 0);
    run_tile(0, 'hFFFE, 3,  16'h00FF, 0, 0);
    run_tile(0, 'h0040, 0,  16'hFFFF, 0, 0);
    run_tile(1, 'h0080, 6,  16'h0F0F, 3, 0);
    run_tile(0, 'h0090, 2,  16'hFFFF, -1, 0);
    run_tile(1, 'h0300, 8,  16'hFFFF, 0, 3);
    run_tile(1, 'h0030, 5,  16'h3C3C, 0, 0);
    run_tile(0, 'h0050, 5,  16'hFFFF, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Weight-load controller sitting directly upstream of `weightFIFO` in the TPU datapath. On a start command it reads a tile of weight rows (one row = FIFO_INPUTS packed 8-bit weights) from weight memory and pushes them into the weight FIFO, one row per cycle. The FIFO itself is unchanged; this block drives its `en` and `weightIn` inputs.

## Interface
- FIFO_INPUTS, 16, lanes per row (FIFO width)
- DATA_WIDTH, 8, bits per weight
- FIFO_DEPTH, 16, max rows per tile
- ADDR_WIDTH, 16, weight-memory address width
- MEM_LATENCY, 1, read latency in cycles, legal 1..4
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command pulse
- base_addr  in  ADDR_WIDTH  address of row 0
- num_rows  in  $clog2(FIFO_DEPTH)+1  rows in tile
- col_mask  in  FIFO_INPUTS  lane enables applied to pushed rows
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_rd_data  in  FIFO_INPUTS*DATA_WIDTH  read data, valid MEM_LATENCY cycles after strobe
- fifo_en  out  FIFO_INPUTS  to weightFIFO `en`
- weight_out  out  FIFO_INPUTS*DATA_WIDTH  to weightFIFO `weightIn`; lane 0 in MSBs

## Operation
- States: IDLE, FETCH, DRAIN, PAD (only when the macro is defined), DONE.
- IDLE: on start, latch base_addr, col_mask, and n = min(num_rows, FIFO_DEPTH), then go to FETCH. If n = 0, go straight to DONE with no reads.
- FETCH: assert mem_rd_en with mem_addr = base_addr + i for i = 0..n-1, one read per cycle. The address wraps modulo 2^ADDR_WIDTH. After the last issue, go to DRAIN.
- A valid shift register of depth MEM_LATENCY tracks outstanding reads. When a returning read is valid: register weight_out <= mem_rd_data and fifo_en <= latched col_mask. In all other cycles fifo_en = 0 and weight_out holds its value.
- DRAIN: wait until the valid pipe is empty, then go to PAD or DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- start is ignored while busy = 1, including the DONE cycle.
- Rows are pushed in ascending address order: row 0 enters the FIFO first.
- Reset mid-operation: return to IDLE and clear all outputs and the valid pipe. In-flight read data is discarded and never pushed.
- Reset values: busy 0, done 0, mem_rd_en 0, mem_addr 0, fifo_en 0, weight_out 0.

## Timing
- Let start be sampled at cycle T and let L = MEM_LATENCY.
- busy = 1 from T+1 through the done cycle inclusive.
- mem_rd_en = 1 in cycles T+1..T+n, with row k's address issued in cycle T+1+k.
- Row k appears on weight_out/fifo_en in cycle T+k+L+2. Pushes are back-to-back with no bubbles.
- Without PAD: done occurs in cycle T+n+L+2. With n = 0: done in T+1 and busy only in T+1.
- Throughput: one row per cycle. Minimum command-to-command spacing is n+L+3 cycles.

## Configuration
- WEIGHT_FETCH_ZPAD_EN defined:
  - After the last real row, PAD pushes zero rows (weight_out = 0, fifo_en = col_mask) back-to-back until exactly FIFO_DEPTH rows have been pushed.
  - Pad rows occupy cycles T+n+L+2..T+FIFO_DEPTH+L+1, and done occurs at T+FIFO_DEPTH+L+2.
  - With n = 0, FIFO_DEPTH zero rows are pushed, starting at T+2.
- Not defined: PAD state is absent, exactly n rows are pushed, and timing is as in Timing.

## Structure
- Shared package `tpu_pkg`:
  - DATA_WIDTH and FIFO_INPUTS defaults, shared with weightFIFO.
  - weight_fetch state enum.
  - Row-type typedef (FIFO_INPUTS*DATA_WIDTH packed).
- One sub-module, `weight_fetch_rdpipe`: a MEM_LATENCY-deep valid shift register with synchronous clear.
- Top level holds the FSM, row/address counters, and output registers.

## Test plan
- Basic tile: L=1, base_addr=0x0010, n=4, col_mask=0xFFFF, memory word = address replicated per lane → reads at 0x10..0x13 in T+1..T+4; rows 0x10..0x13 pushed in T+3..T+6 with fifo_en=0xFFFF; done at T+7.
- Clamp/latency: L=3, num_rows=20 → exactly 16 reads and 16 pushes; done at T+21.
- Wrap and mask: base_addr=0xFFFE, n=3, col_mask=0x00FF → reads at 0xFFFE, 0xFFFF, 0x0000; fifo_en=0x00FF on each push.
- Zero rows and ignored start: num_rows=0 → no mem_rd_en, done at T+1. Separately, a second start issued mid-tile is ignored: read count unchanged.
- Reset mid-fetch: L=2, reset asserted in T+3 of an n=8 tile → all outputs 0 the next cycle, no further fifo_en pulses. A new start after reset works normally.
- ZPAD build: n=5, L=1 → 5 data rows then 11 zero rows with fifo_en=col_mask; done at T+19.
